llr_frame_packer: RTL and testbench

Parametrised successor to the fixed 8-lane LLR multiplexer and hard-wired lane swap in the receive chain. It sits between the deinterleaver and the LDPC decoder.
- Collects serial soft LLRs into pLLR_NUM-wide decoder words.
- Applies the configurable group-reversal lane map.
- Enforces the codeword length.
- Provides valid/ready backpressure in both directions.

---
 rtl/llr_pack_pkg.sv | 9 +
 rtl/llr_word_reg.sv | 26 ++
 rtl/llr_frame_packer.sv | 113 +++++++++++
 tb/tb_llr_frame_packer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/llr_pack_pkg.sv
// llr_pack_pkg: shared types and the decoder lane map for the LLR frame packer.
package llr_pack_pkg;
    localparam int LLR_W = 5;
    typedef logic signed [LLR_W-1:0] llr_t;
    typedef enum logic [1:0] {IDLE, FILL, DROP} state_t;
    function automatic int lane_of(input int k, input int group, input bit reverse);
        return reverse ? (k / group) * group + (group - 1 - k % group) : k;
    endfunction
endpackage

// File: rtl/llr_word_reg.sv
// llr_word_reg: one-entry output register, holds its word until the consumer takes it.
module llr_word_reg #(
    parameter int pW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [pW-1:0] din,
    input  logic          irdy,
    output logic          oval,
    output logic [pW-1:0] odat,
    output logic          free
);
    assign free = !oval || irdy;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            oval <= 1'b0;
            odat <= '0;
        end else if (load) begin
            oval <= 1'b1;
            odat <= din;
        end else if (irdy) begin
            oval <= 1'b0;
        end
    end
endmodule

// File: rtl/llr_frame_packer.sv
// llr_frame_packer: packs serial soft LLRs into lane-mapped decoder words
// with codeword length enforcement and valid/ready flow control.
module llr_frame_packer
    import llr_pack_pkg::*;
#(
    parameter int pLLR_W     = 5,
    parameter int pLLR_NUM   = 8,
    parameter int pGROUP     = 4,
    parameter int pREVERSE   = 1,
    parameter int pFRAME_LEN = 2304
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          isop,
    input  logic                          ieop,
    input  logic                          ival,
    input  logic [pLLR_W-1:0]             idat,
    output logic                          ordy,
    input  logic                          irdy,
    output logic                          oval,
    output logic                          osop,
    output logic                          oeop,
    output logic [pLLR_NUM*pLLR_W-1:0]    odat,
    output logic [$clog2(pLLR_NUM+1)-1:0] ocnt,
    output logic                          oerr_short,
    output logic                          oerr_long
);
    localparam int CW = $clog2(pLLR_NUM + 1);
    localparam int SW = $clog2(pFRAME_LEN + 1);
    localparam int DW = pLLR_NUM * pLLR_W;

    typedef struct packed {
        logic          sop;
        logic          eop;
        logic [CW-1:0] cnt;
        logic [DW-1:0] lanes;
    } word_t;

    if (pFRAME_LEN % pLLR_NUM != 0) begin : g_len_chk
        $error("pFRAME_LEN must be a multiple of pLLR_NUM");
    end
    if (pLLR_NUM % pGROUP != 0) begin : g_grp_chk
        $error("pLLR_NUM must be a multiple of pGROUP");
    end

    state_t        state;
    logic [CW-1:0] lane_cnt, cnt_base, nl;
    logic [SW-1:0] sym_cnt, ns;
    word_t         acc, word, q;
    logic          pending, long_pend, free, take, start, upd, close, pend_nx, ld;
    int            lane;

    // acc doubles as the parking slot for a finished word while the output register is busy
    assign ordy = rst && !(pending && !free);

    always_comb begin
        take     = ival && ordy;
        start    = take && isop;
        upd      = take && (isop || state == FILL);
        cnt_base = start ? '0 : lane_cnt;
        nl       = cnt_base + CW'(1);
        ns       = (start ? '0 : sym_cnt) + SW'(1);
        lane     = lane_of(int'(cnt_base), pGROUP, pREVERSE != 0);
        word     = (start || pending) ? '0 : acc;
        for (int i = 0; i < pLLR_NUM; i++)
            if (i == lane) word.lanes[i*pLLR_W +: pLLR_W] = idat;
        word.sop = start || word.sop;
        word.eop = ieop || ns == SW'(pFRAME_LEN);
        word.cnt = nl;
        close    = upd && (nl == CW'(pLLR_NUM) || word.eop);
        pend_nx  = (pending && !free) || (close && (pending || !free));
        ld       = free && (pending || close);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            lane_cnt   <= '0;
            sym_cnt    <= '0;
            acc        <= '0;
            pending    <= 1'b0;
            long_pend  <= 1'b0;
            oerr_short <= 1'b0;
            oerr_long  <= 1'b0;
        end else begin
            oerr_short <= upd && ((state == FILL && isop) || (ieop && ns != SW'(pFRAME_LEN)));
            oerr_long  <= take && !isop && state == DROP && long_pend;
            pending    <= pend_nx;
            if (take) long_pend <= upd && word.eop && !ieop;
            if (upd) begin
                lane_cnt <= close ? '0 : nl;
                sym_cnt  <= word.eop ? '0 : ns;
                state    <= !word.eop ? FILL : ieop ? IDLE : DROP;
                acc      <= (close && !pend_nx) ? '0 : word;
            end else if (pending && free) begin
                acc <= '0;
            end
        end
    end

    llr_word_reg #(.pW($bits(word_t))) u_word_reg (
        .clk  (clk),
        .rst  (rst),
        .load (ld),
        .din  (pending ? acc : word),
        .irdy (irdy),
        .oval (oval),
        .odat (q),
        .free (free)
    );

    assign {osop, oeop, ocnt, odat} = q;
endmodule

// File: tb/tb_llr_frame_packer.sv
// tb_llr_frame_packer: directed and randomized checks of two packers (reversed and straight
// lane maps) against a queue-based reference model of the codeword rules.
module tb_llr_frame_packer;
    localparam int NUM = 8;
    localparam int G   = 4;
    localparam int FL  = 16;

    typedef struct packed {logic sop; logic eop; logic [3:0] cnt; logic [39:0] dat;} wexp_t;
    typedef struct {bit sop; bit eop; logic [4:0] dat;} item_t;

    logic clk = 0, rst = 0, isop = 0, ieop = 0, ival = 0, irdy = 1;
    logic [4:0] idat = '0;
    logic ordy_a, oval_a, osop_a, oeop_a, es_a, el_a;
    logic ordy_b, oval_b, osop_b, oeop_b, es_b, el_b;
    logic [39:0] odat_a, odat_b;
    logic [3:0] ocnt_a, ocnt_b;

    int total = 0, bad = 0;
    item_t items[$];
    wexp_t qa[$], qb[$];
    logic [4:0] cur[$];
    bit in_frame = 0, first = 0, long_owed = 0, exp_short = 0, exp_long = 0;
    int sym = 0, gap_pct = 0, hold_left = 0, hold_acc = 0, hold_stall = 0;
    bit rdy_rand = 0, arm = 0, prev_hold = 0;
    logic [46:0] prev_out = '0;

    always #5 clk = ~clk;

    llr_frame_packer #(.pLLR_W(5), .pLLR_NUM(NUM), .pGROUP(G), .pREVERSE(1), .pFRAME_LEN(FL)) dut_a (
        .clk(clk), .rst(rst), .isop(isop), .ieop(ieop), .ival(ival), .idat(idat), .ordy(ordy_a),
        .irdy(irdy), .oval(oval_a), .osop(osop_a), .oeop(oeop_a), .odat(odat_a), .ocnt(ocnt_a),
        .oerr_short(es_a), .oerr_long(el_a));

    llr_frame_packer #(.pLLR_W(5), .pLLR_NUM(NUM), .pGROUP(G), .pREVERSE(0), .pFRAME_LEN(FL)) dut_b (
        .clk(clk), .rst(rst), .isop(isop), .ieop(ieop), .ival(ival), .idat(idat), .ordy(ordy_b),
        .irdy(irdy), .oval(oval_b), .osop(osop_b), .oeop(oeop_b), .odat(odat_b), .ocnt(ocnt_b),
        .oerr_short(es_b), .oerr_long(el_b));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic emit(input bit e);
        wexp_t a = '0;
        wexp_t b;
        a.sop = first;
        a.eop = e;
        a.cnt = 4'(cur.size());
        b = a;
        for (int k = 0; k < cur.size(); k++) begin
            int ra = (k / G) * G + (G - 1 - k % G);
            a.dat[ra*5 +: 5] = cur[k];
            b.dat[k*5 +: 5] = cur[k];
        end
        qa.push_back(a);
        qb.push_back(b);
        first = 0;
        cur.delete();
    endtask

    task automatic model_accept(input bit s, input bit e, input logic [4:0] d);
        if (s) begin
            if (in_frame) exp_short = 1;
            cur.delete();
            sym = 0;
            in_frame = 1;
            first = 1;
            long_owed = 0;
        end else if (!in_frame) begin
            if (long_owed) exp_long = 1;
            long_owed = 0;
            return;
        end
        cur.push_back(d);
        sym++;
        if (e || sym == FL) begin
            emit(1);
            in_frame = 0;
            if (e && sym < FL) exp_short = 1;
            if (!e) long_owed = 1;
        end else if (cur.size() == NUM) begin
            emit(0);
        end
    endtask

    task automatic step();
        bit drove, in_hold;
        @(negedge clk);
        drove = items.size() > 0 && $urandom_range(0, 99) >= gap_pct;
        ival = drove;
        isop = drove ? items[0].sop : 1'($urandom);
        ieop = drove ? items[0].eop : 1'($urandom);
        idat = drove ? items[0].dat : 5'($urandom);
        in_hold = 0;
        if (hold_left > 0) begin
            hold_left--;
            in_hold = 1;
        end else if (arm && oval_a) begin
            arm = 0;
            hold_left = 9;
            in_hold = 1;
        end
        irdy = in_hold ? 1'b0 : rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        #1;
        check("ordy_lanes_agree", ordy_b, ordy_a);
        check("err_short_a", es_a, exp_short);
        check("err_short_b", es_b, exp_short);
        check("err_long_a", el_a, exp_long);
        check("err_long_b", el_b, exp_long);
        if (prev_hold) check("hold_stable", {oval_a, osop_a, oeop_a, ocnt_a, odat_a}, prev_out);
        prev_hold = oval_a && !irdy;
        prev_out = {oval_a, osop_a, oeop_a, ocnt_a, odat_a};
        if (oval_a && irdy) begin
            if (qa.size() > 0) check("word_rev", {osop_a, oeop_a, ocnt_a, odat_a}, qa.pop_front());
            else check("extra_word_rev", 1, 0);
        end
        if (oval_b && irdy) begin
            if (qb.size() > 0) check("word_straight", {osop_b, oeop_b, ocnt_b, odat_b}, qb.pop_front());
            else check("extra_word_straight", 1, 0);
        end
        exp_short = 0;
        exp_long = 0;
        if (in_hold && ival) begin
            if (ordy_a) hold_acc++;
            else hold_stall++;
        end
        if (ival && ordy_a) begin
            model_accept(isop, ieop, idat);
            if (drove) void'(items.pop_front());
        end
    endtask

    task automatic push_frame(input int n, input int base, input bit s, input bit e);
        for (int k = 0; k < n; k++) begin
            item_t it;
            it.sop = s && k == 0;
            it.eop = e && k == n - 1;
            it.dat = 5'(base + k);
            items.push_back(it);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((items.size() > 0 || qa.size() > 0 || qb.size() > 0) && n < 3000) begin
            step();
            n++;
        end
        check("drain_in_budget", n < 3000, 1);
        repeat (2) step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 0;
        ival = 0;
        #1;
        check("rst_ctrl", {ordy_a, oval_a, osop_a, oeop_a, ocnt_a, es_a, el_a}, 0);
        check("rst_data", {odat_a, odat_b}, 0);
        cur.delete();
        qa.delete();
        qb.delete();
        in_frame = 0;
        long_owed = 0;
        exp_short = 0;
        exp_long = 0;
        prev_hold = 0;
        repeat (2) @(negedge clk);
        rst = 1;
    endtask

    initial begin
        #1;
        check("reset_ctrl", {ordy_a, oval_a, osop_a, oeop_a, ocnt_a, es_a, el_a}, 0);
        check("reset_data", odat_a, 0);
        repeat (3) @(negedge clk);
        rst = 1;
        push_frame(16, 0, 1, 1);
        drain();
        arm = 1;
        push_frame(16, 0, 1, 1);
        push_frame(16, 16, 1, 1);
        drain();
        check("bp_accepts_during_hold", hold_acc, 8);
        check("bp_stall_cycles", hold_stall, 2);
        push_frame(11, 0, 1, 1);
        drain();
        push_frame(20, 0, 1, 0);
        push_frame(16, 0, 1, 1);
        drain();
        push_frame(5, 0, 1, 0);
        push_frame(16, 5, 1, 1);
        drain();
        push_frame(1, 9, 1, 1);
        push_frame(8, 3, 1, 1);
        drain();
        push_frame(5, 0, 1, 0);
        drain();
        do_reset();
        push_frame(3, 20, 0, 0);
        push_frame(16, 0, 1, 1);
        drain();
        gap_pct = 25;
        rdy_rand = 1;
        for (int f = 0; f < 40; f++) begin
            int len = $urandom_range(1, 22);
            if ($urandom_range(0, 4) == 0) push_frame(2, $urandom, 0, $urandom_range(0, 1) == 1);
            push_frame(len, $urandom, 1, $urandom_range(0, 9) < 7);
        end
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
